// File: rtl/dsp_v6_pkg.sv
// Shared types and helpers for the V6 DSP vector blocks.
package dsp_v6_pkg;

  localparam int DEF_REG_WIDTH = 16;
  localparam int DEF_VECTOR    = 6;

  typedef logic [DEF_REG_WIDTH-1:0] lane_t;
  typedef lane_t [DEF_VECTOR-1:0]   vec_t;

  // Lane-index width; a single-lane vector still gets a 1-bit index.
  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_serializer_v6_if.sv
// Vector-in / lane-out stream bundle for the V6 serializer.
interface vector_serializer_v6_if
  import dsp_v6_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int VECTOR    = DEF_VECTOR
);
  localparam int IDXW = idxw(VECTOR);

  logic                              in_valid;
  logic                              in_ready;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  a_in;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  b_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [REG_WIDTH-1:0]              a_out;
  logic [REG_WIDTH-1:0]              b_out;
  logic [IDXW-1:0]                   out_lane;
  logic                              out_last;

  // Producer of vectors and consumer of lanes.
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, a_out, b_out, out_lane, out_last
  );

  // The serializer itself.
  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, a_out, b_out, out_lane, out_last
  );

endinterface

// File: rtl/vector_serializer_v6.sv
// Parallel-to-serial output stage: takes an (a, b) vector pair per handshake
// and emits one lane pair per cycle. Active + pending slots give bubble-free
// back-to-back vectors while in_ready stays a pure register output.
module vector_serializer_v6
  import dsp_v6_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int VECTOR    = DEF_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_serializer_v6_if.slave bus
);

  localparam int IDXW = idxw(VECTOR);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VECTOR - 1);

  typedef logic [VECTOR-1:0][REG_WIDTH-1:0] slot_t;

  slot_t           act_a, act_b;
  slot_t           pnd_a, pnd_b;
  logic            act_vld, pnd_vld;
  logic [IDXW-1:0] idx;

  logic is_last, out_hs, drain, accept;

  // Handshake decode; everything here is built from registers plus the two
  // handshake inputs, so in_ready never sees a combinational path.
  always_comb begin
    is_last = (idx == LAST_IDX);
    out_hs  = act_vld && bus.out_ready;
    drain   = out_hs && is_last;
    accept  = bus.in_valid && !pnd_vld;
  end

  assign bus.in_ready  = !pnd_vld;
  assign bus.out_valid = act_vld;
  assign bus.a_out     = act_a[idx];
  assign bus.b_out     = act_b[idx];
  assign bus.out_lane  = idx;
  assign bus.out_last  = is_last;

  // Slot management: advance lane, promote pending on drain, or load new vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_a   <= '0;
      act_b   <= '0;
      pnd_a   <= '0;
      pnd_b   <= '0;
      act_vld <= 1'b0;
      pnd_vld <= 1'b0;
      idx     <= '0;
    end else if (drain) begin
      // Last lane leaves: refill active from pending, else from the input
      // (in_ready is 1 whenever pending is empty), else go idle.
      idx <= '0;
      if (pnd_vld) begin
        act_a   <= pnd_a;
        act_b   <= pnd_b;
        pnd_vld <= 1'b0;
      end else if (accept) begin
        act_a <= bus.a_in;
        act_b <= bus.b_in;
      end else begin
        act_vld <= 1'b0;
      end
    end else begin
      if (out_hs) idx <= idx + 1'b1;
      if (accept) begin
        if (!act_vld) begin
          act_a   <= bus.a_in;
          act_b   <= bus.b_in;
          act_vld <= 1'b1;
          idx     <= '0;
        end else begin
          pnd_a   <= bus.a_in;
          pnd_b   <= bus.b_in;
          pnd_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_serializer_v6.sv
// Bench for vector_serializer_v6: a 6-lane and a 1-lane build run side by
// side on the same handshake stimulus, each compared against a flat queue of
// expected lane records.
module tb_vector_serializer_v6;

  typedef logic [5:0][15:0] v6_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lane;
    bit          last;
  } rec_t;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int acc6   = 0;

  rec_t q6[$];
  rec_t q1[$];

  vector_serializer_v6_if #(.REG_WIDTH(16), .VECTOR(6)) bus6 ();
  vector_serializer_v6_if #(.REG_WIDTH(16), .VECTOR(1)) bus1 ();

  vector_serializer_v6 #(.REG_WIDTH(16), .VECTOR(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  vector_serializer_v6 #(.REG_WIDTH(16), .VECTOR(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic v6_t rnd_vec();
    v6_t r;
    for (int l = 0; l < 6; l++) r[l] = 16'($urandom);
    return r;
  endfunction

  // A vector is in flight while any of its lanes is still owed; upstream may
  // hand over a new one while fewer than two are in flight.
  function automatic bit rdy_exp(input int lanes_left, input int v);
    return ((lanes_left + v - 1) / v) < 2;
  endfunction

  task automatic check_outputs();
    chk("v6_out_valid", 32'(bus6.out_valid), 32'(q6.size() > 0));
    chk("v6_in_ready",  32'(bus6.in_ready),  32'(rdy_exp(q6.size(), 6)));
    if (q6.size() > 0) begin
      chk("v6_a_out",    32'(bus6.a_out),    32'(q6[0].a));
      chk("v6_b_out",    32'(bus6.b_out),    32'(q6[0].b));
      chk("v6_out_lane", 32'(bus6.out_lane), 32'(q6[0].lane));
      chk("v6_out_last", 32'(bus6.out_last), 32'(q6[0].last));
    end
    chk("v1_out_valid", 32'(bus1.out_valid), 32'(q1.size() > 0));
    chk("v1_in_ready",  32'(bus1.in_ready),  32'(rdy_exp(q1.size(), 1)));
    if (q1.size() > 0) begin
      chk("v1_a_out",    32'(bus1.a_out),    32'(q1[0].a));
      chk("v1_b_out",    32'(bus1.b_out),    32'(q1[0].b));
      chk("v1_out_lane", 32'(bus1.out_lane), 32'(0));
      chk("v1_out_last", 32'(bus1.out_last), 32'(1));
    end
  endtask

  // One clock: check what the last edge produced, then drive the next inputs
  // and advance the reference to what the coming edge must do.
  task automatic step(input bit iv, input bit ordy, input v6_t va, input v6_t vb);
    bit r6, r1;
    @(negedge clk);
    check_outputs();
    bus6.in_valid  = iv;
    bus6.out_ready = ordy;
    bus6.a_in      = va;
    bus6.b_in      = vb;
    bus1.in_valid  = iv;
    bus1.out_ready = ordy;
    bus1.a_in      = va[0];
    bus1.b_in      = vb[0];
    r6 = rdy_exp(q6.size(), 6);
    r1 = rdy_exp(q1.size(), 1);
    if (q6.size() > 0 && ordy) void'(q6.pop_front());
    if (q1.size() > 0 && ordy) void'(q1.pop_front());
    if (iv && r6) begin
      acc6++;
      for (int l = 0; l < 6; l++)
        q6.push_back('{a: va[l], b: vb[l], lane: l, last: (l == 5)});
    end
    if (iv && r1) q1.push_back('{a: va[0], b: vb[0], lane: 0, last: 1'b1});
  endtask

  task automatic reset_checks();
    chk("rst_v6_out_valid", 32'(bus6.out_valid), 32'(0));
    chk("rst_v6_in_ready",  32'(bus6.in_ready),  32'(1));
    chk("rst_v6_out_lane",  32'(bus6.out_lane),  32'(0));
    chk("rst_v6_a_out",     32'(bus6.a_out),     32'(0));
    chk("rst_v6_b_out",     32'(bus6.b_out),     32'(0));
    chk("rst_v6_out_last",  32'(bus6.out_last),  32'(0));
    chk("rst_v1_out_valid", 32'(bus1.out_valid), 32'(0));
    chk("rst_v1_in_ready",  32'(bus1.in_ready),  32'(1));
    chk("rst_v1_out_lane",  32'(bus1.out_lane),  32'(0));
    chk("rst_v1_out_last",  32'(bus1.out_last),  32'(1));
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    bus6.in_valid  = 1'b0;
    bus1.in_valid  = 1'b0;
    #1;
    reset_checks();
    q6.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    v6_t da, db;
    rst_n          = 1'b0;
    bus6.in_valid  = 1'b0;
    bus6.out_ready = 1'b0;
    bus6.a_in      = '0;
    bus6.b_in      = '0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.a_in      = '0;
    bus1.b_in      = '0;
    #1;
    reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single vector with recognisable lane values.
    for (int l = 0; l < 6; l++) begin
      da[l] = 16'(l);
      db[l] = 16'(16'h100 + l);
    end
    step(1'b1, 1'b1, da, db);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());

    // Back-to-back: three vectors offered continuously, no output stall.
    acc6 = 0;
    for (int i = 0; i < 24; i++) step(acc6 < 3, 1'b1, rnd_vec(), rnd_vec());
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());

    // Backpressure from lane 2 with upstream pushing the whole time.
    step(1'b1, 1'b1, rnd_vec(), rnd_vec());
    step(1'b0, 1'b1, rnd_vec(), rnd_vec());
    step(1'b0, 1'b1, rnd_vec(), rnd_vec());
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, rnd_vec(), rnd_vec());
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());

    // Accept lands on the same edge as the last lane with pending empty.
    step(1'b1, 1'b1, rnd_vec(), rnd_vec());
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());
    step(1'b1, 1'b1, rnd_vec(), rnd_vec());
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());

    // Reset while a vector is half out and another is pending.
    for (int i = 0; i < 4; i++) step(1'b1, i < 2, rnd_vec(), rnd_vec());
    mid_reset();
    step(1'b1, 1'b1, rnd_vec(), rnd_vec());
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());

    // Random handshakes on both sides, with one more reset partway.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), rnd_vec(), rnd_vec());
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, rnd_vec(), rnd_vec());

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_serializer_v6.md
# vector_serializer_v6

Parallel-to-serial output stage for the V6 DSP vector datapath. Accepts one VECTOR-lane pair of sample vectors (a, b) per handshake, as produced by the vector delay stage, and emits the lanes one pair per cycle on a valid/ready stream toward the scalar back end. A two-slot buffer (active + pending) sustains back-to-back vectors with no bubble, and keeps in_ready purely register-driven.

## Interface
- REG_WIDTH, 16, bits per lane sample
- VECTOR, 6, lanes per vector (legal: VECTOR >= 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  vector pair on a_in/b_in is valid
- in_ready  output  1  serializer can accept a vector this cycle
- a_in  input  [REG_WIDTH-1:0] x [VECTOR]  a-vector, lane 0 first out
- b_in  input  [REG_WIDTH-1:0] x [VECTOR]  b-vector, lane 0 first out
- out_valid  output  1  a_out/b_out carry a valid lane
- out_ready  input  1  downstream accepts the current lane
- a_out  output  REG_WIDTH  current a lane sample
- b_out  output  REG_WIDTH  current b lane sample
- out_lane  output  IDXW = max(1, $clog2(VECTOR))  index of the current lane
- out_last  output  1  current lane is VECTOR-1

## Operation
- State: active slot (a, b vectors, active_valid, lane index idx), pending slot (a, b vectors, pending_valid).
- in_ready = !pending_valid. Depends on registers only, never on out_ready or in_valid.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready && out_last.
- out_valid = active_valid. a_out/b_out = active[idx]. out_lane = idx. out_last = (idx == VECTOR-1).
- Output handshake (out_valid && out_ready) with !out_last: idx <= idx+1.
- Drain with pending_valid: active <= pending, idx <= 0, pending_valid <= 0. A simultaneous accept is impossible because in_ready = 0.
- Drain with !pending_valid: if Accept, the new vector loads into active with idx <= 0 and active_valid stays 1. Otherwise active_valid <= 0.
- Accept without Drain: if !active_valid, load active, idx <= 0. Otherwise load pending, pending_valid <= 1.
- While out_valid && !out_ready, a_out, b_out, out_lane and out_last hold stable.
- VECTOR = 1: every lane is last, idx stays 0, and each vector drains in one output handshake.
- Lane samples pass through bit-exact. No arithmetic is performed.

## Timing
- Reset (async assert, sync-safe deassert via clk): active_valid = 0, pending_valid = 0, idx = 0, and both slot data registers are 0.
- Resulting outputs during reset: out_valid = 0, in_ready = 1, a_out = b_out = 0, out_lane = 0, out_last = (VECTOR == 1).
- Latency: a vector accepted at edge t presents lane 0 on out_valid in the cycle after t.
- Throughput: with out_ready held high, VECTOR output cycles per vector and zero idle cycles between consecutive vectors.
- Capacity: one vector being serialized plus one vector buffered. The upstream stalls only when both slots are full.
- Reset mid-vector: the partially emitted vector and any pending vector are discarded. After rst_n deasserts, the next accepted vector starts at lane 0.

## Structure
- Shared package dsp_v6_pkg holds:
  - lane_t = logic [REG_WIDTH-1:0]
  - the vector typedef
  - the IDXW width function, reused by other V6 vector blocks
- Single module, no sub-modules. Both slots are plain registers inside vector_serializer_v6.

## Test plan
- Reset: assert rst_n = 0 mid-stream -> out_valid = 0, in_ready = 1, out_lane = 0 immediately, without waiting for a clock edge.
- Single vector: a_in = {0x0005,0x0004,0x0003,0x0002,0x0001,0x0000}, so lane 0 = 0x0000; b_in = a + 0x100; out_ready = 1 -> six cycles with a_out 0x0000..0x0005, b_out 0x0100..0x0105; out_last only on lane 5; out_valid = 0 afterwards.
- Back-to-back: three vectors offered continuously, out_ready = 1 -> 18 consecutive valid cycles, no gap, lane order preserved across vector boundaries.
- Backpressure: out_ready = 0 for 10 cycles starting at lane 2, with in_valid held high -> a_out stays at lane 2; pending fills; in_ready drops to 0 one cycle after the second accept; no vector lost.
- Drain/accept collision: pending empty, Accept coincides with Drain -> the next cycle shows the new vector's lane 0 with out_valid continuously high.
- VECTOR = 1 build: each accept yields exactly one output with out_last = 1 and out_lane = 0. Sustained rate is one vector per cycle with out_ready = 1.
